clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 63 ++++++
 tb/tb_clk_div_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel divides clk_in by a
// runtime divisor, producing a registered square clock and a per-period tick.
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_val,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0]            clk_q, clk_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (load[i]) begin
        cnt_d[i] = '0;
        div_d[i] = div_val[i*WIDTH +: WIDTH];
        clk_d[i] = 1'b0;
      end else if (enable[i] && (div_q[i] != '0)) begin
        // New divisor is only taken at the wrap, so a period never gets cut short.
        if (cnt_q[i] == div_q[i] - WIDTH'(1)) begin
          cnt_d[i] = '0;
          div_d[i] = div_val[i*WIDTH +: WIDTH];
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
        // Outputs derive from next-state values so they line up with cnt_q.
        clk_d[i]  = (div_d[i] > WIDTH'(1)) && (cnt_d[i] >= (div_d[i] >> 1));
        tick_d[i] = (div_d[i] != '0) && (cnt_d[i] == div_d[i] - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      div_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a per-cycle reference model queues the
// expected clk_out/tick vectors, plus directed period/phase measurements.
module tb_clk_div_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk_in = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   load;
  logic [CH*W-1:0] div_val;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned mcnt [CH];
  int unsigned mdiv [CH];
  logic [CH-1:0] mclk, mtick;
  logic [2*CH-1:0] exp_q [$];

  clk_div_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .enable  (enable),
    .load    (load),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      mcnt[c] = 0;
      mdiv[c] = 0;
    end
    mclk  = '0;
    mtick = '0;
  endfunction

  function automatic void model_step();
    int unsigned dv;
    for (int c = 0; c < CH; c++) begin
      dv = div_val[c*W +: W];
      mtick[c] = 1'b0;
      if (load[c]) begin
        mcnt[c] = 0;
        mdiv[c] = dv;
        mclk[c] = 1'b0;
      end else if (enable[c] && mdiv[c] > 0) begin
        mcnt[c] = mcnt[c] + 1;
        if (mcnt[c] == mdiv[c]) begin
          mcnt[c] = 0;
          mdiv[c] = dv;
        end
        mtick[c] = (mdiv[c] > 0) && (mcnt[c] + 1 == mdiv[c]);
        mclk[c]  = (mdiv[c] >= 2) && (mcnt[c] >= mdiv[c] / 2);
      end
    end
  endfunction

  task automatic step();
    model_step();
    exp_q.push_back({mclk, mtick});
    @(posedge clk_in);
    #1;
    check("outs", 32'({clk_out, tick}), 32'(exp_q.pop_front()));
  endtask

  task automatic set_div(input int c, input int unsigned v);
    div_val[c*W +: W] = W'(v);
  endtask

  task automatic run_until_tick(input int c, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[c] && n < 50);
  endtask

  int n, hi0, hi1, tk0, tk1, first0, first1, guard;

  initial begin
    reset_n = 1'b0;
    enable  = '0;
    load    = '0;
    div_val = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_clk", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset_n = 1'b1;
    enable  = '1;
    repeat (3) step();

    // ch0 /10 and ch1 /7 loaded together; 70 cycles cover whole periods of both
    set_div(0, 10);
    set_div(1, 7);
    load = 4'b0011;
    step();
    load = '0;
    hi0 = 0; hi1 = 0; tk0 = 0; tk1 = 0; first0 = 0; first1 = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      hi0 += int'(clk_out[0]);
      hi1 += int'(clk_out[1]);
      tk0 += int'(tick[0]);
      tk1 += int'(tick[1]);
      if (tick[0] && first0 == 0) first0 = k;
      if (tick[1] && first1 == 0) first1 = k;
    end
    check("ch0_high", 32'(hi0), 32'd35);
    check("ch0_ticks", 32'(tk0), 32'd7);
    check("ch0_first_tick", 32'(first0), 32'd9);
    check("ch1_high", 32'(hi1), 32'd40);
    check("ch1_ticks", 32'(tk1), 32'd10);
    check("ch1_first_tick", 32'(first1), 32'd6);

    // retune ch0 to 4 mid-period
    guard = 0;
    while (mcnt[0] != 3 && guard < 30) begin
      step();
      guard++;
    end
    set_div(0, 4);
    run_until_tick(0, n);
    check("retune_finish", 32'(n), 32'd6);
    hi0 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 2) check("retune_low", 32'(clk_out[0]), 32'd0);
      else check("retune_high", 32'(clk_out[0]), 32'd1);
    end
    check("retune_tick", 32'(tick[0]), 32'd1);

    // back to /10, then freeze at cnt 6
    set_div(0, 10);
    guard = 0;
    while (!(mdiv[0] == 10 && mcnt[0] == 6) && guard < 40) begin
      step();
      guard++;
    end
    enable[0] = 1'b0;
    hi0 = 0; tk0 = 0;
    repeat (5) begin
      step();
      hi0 += int'(clk_out[0]);
      tk0 += int'(tick[0]);
    end
    check("freeze_clk", 32'(hi0), 32'd5);
    check("freeze_tick", 32'(tk0), 32'd0);
    enable[0] = 1'b1;
    run_until_tick(0, n);
    check("resume_tick", 32'(n), 32'd3);

    // all channels /8, phase-aligned
    for (int c = 0; c < CH; c++) set_div(c, 8);
    load = '1;
    step();
    load = '0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("align8", 32'(clk_out), ((k % 8) >= 4) ? 32'hF : 32'h0);
    end

    for (int c = 0; c < CH; c++) set_div(c, 1);
    load = '1;
    step();
    check("load1_tick", 32'(tick), 32'h0);
    load = '0;
    repeat (4) begin
      step();
      check("div1_tick", 32'(tick), 32'hF);
      check("div1_clk", 32'(clk_out), 32'h0);
    end

    for (int c = 0; c < CH; c++) set_div(c, 0);
    load = '1;
    step();
    load = '0;
    for (int c = 0; c < CH; c++) set_div(c, 5);
    repeat (6) begin
      step();
      check("div0_out", 32'({clk_out, tick}), 32'h0);
    end

    // async reset in the high phase of ch2
    set_div(2, 6);
    load = 4'b0100;
    step();
    load = '0;
    guard = 0;
    while (!mclk[2] && guard < 20) begin
      step();
      guard++;
    end
    check("ch2_high_before_rst", 32'(clk_out[2]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clk", 32'(clk_out), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    model_reset();
    @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    repeat (8) step();
    load = 4'b0100;
    step();
    load = '0;
    run_until_tick(2, n);
    check("ch2_reload_tick", 32'(n), 32'd5);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
